idex_fwd_reg_b: RTL and testbench

- Lane-B ID/EX pipeline register. Captures lane-B decode-stage operands and control on each advancing clock edge.
- Pre-computes the EX-stage forward selects (ForwardB1_E, ForwardB2_E) one cycle early, by comparing the decode source registers against the destinations that will sit in M and W next cycle. The lane-B EX forward muxes therefore get registered select bits.
- Also flags load-use hazards for the hazard unit and counts bubbles issued into lane-B EX.

---
 rtl/idex_fwd_reg_b_pkg.sv | 20 ++
 rtl/idex_fwd_reg_b_if.sv | 58 +++++
 rtl/idex_fwd_reg_b_fwd_sel_calc.sv | 27 ++
 rtl/idex_fwd_reg_b.sv | 156 +++++++++++++++
 tb/tb_idex_fwd_reg_b.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/idex_fwd_reg_b_pkg.sv
// Shared types and default widths for the lane-B ID/EX register slice.
package idex_fwd_reg_b_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned CNTW = 32;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_t;

endpackage

// File: rtl/idex_fwd_reg_b_if.sv
// Lane-B D-stage inputs, backend destination info and registered E-stage outputs.
interface idex_fwd_reg_b_if #(
  parameter int unsigned XLEN = idex_fwd_reg_b_pkg::XLEN,
  parameter int unsigned REGW = idex_fwd_reg_b_pkg::REGW,
  parameter int unsigned CNTW = idex_fwd_reg_b_pkg::CNTW
);

  logic            StallB_E;
  logic            FlushB_E;
  logic            ValidB_D;
  logic [XLEN-1:0] RD1B_D;
  logic [XLEN-1:0] RD2B_D;
  logic [XLEN-1:0] ImmExtB_D;
  logic [XLEN-1:0] PCB_D;
  logic [REGW-1:0] Rs1B_D;
  logic [REGW-1:0] Rs2B_D;
  logic [REGW-1:0] RdB_D;
  logic            RegWriteB_D;
  logic            MemWriteB_D;
  logic [1:0]      ResultSrcB_D;
  logic [REGW-1:0] RdB_M;
  logic            RegWriteB_M;

  logic            ValidB_E;
  logic [XLEN-1:0] RD1B_E;
  logic [XLEN-1:0] RD2B_E;
  logic [XLEN-1:0] ImmExtB_E;
  logic [XLEN-1:0] PCB_E;
  logic [REGW-1:0] Rs1B_E;
  logic [REGW-1:0] Rs2B_E;
  logic [REGW-1:0] RdB_E;
  logic            RegWriteB_E;
  logic            MemWriteB_E;
  logic [1:0]      ResultSrcB_E;
  logic [1:0]      ForwardB1_E;
  logic [1:0]      ForwardB2_E;
  logic            LoadUseB_D;
  logic [CNTW-1:0] BubbleCntB;

  modport slave (
    input  StallB_E, FlushB_E, ValidB_D, RD1B_D, RD2B_D, ImmExtB_D, PCB_D,
           Rs1B_D, Rs2B_D, RdB_D, RegWriteB_D, MemWriteB_D, ResultSrcB_D,
           RdB_M, RegWriteB_M,
    output ValidB_E, RD1B_E, RD2B_E, ImmExtB_E, PCB_E, Rs1B_E, Rs2B_E, RdB_E,
           RegWriteB_E, MemWriteB_E, ResultSrcB_E, ForwardB1_E, ForwardB2_E,
           LoadUseB_D, BubbleCntB
  );

  modport master (
    output StallB_E, FlushB_E, ValidB_D, RD1B_D, RD2B_D, ImmExtB_D, PCB_D,
           Rs1B_D, Rs2B_D, RdB_D, RegWriteB_D, MemWriteB_D, ResultSrcB_D,
           RdB_M, RegWriteB_M,
    input  ValidB_E, RD1B_E, RD2B_E, ImmExtB_E, PCB_E, Rs1B_E, Rs2B_E, RdB_E,
           RegWriteB_E, MemWriteB_E, ResultSrcB_E, ForwardB1_E, ForwardB2_E,
           LoadUseB_D, BubbleCntB
  );

endinterface

// File: rtl/idex_fwd_reg_b_fwd_sel_calc.sv
// Forward select for one source index: newest producer (E, next in M) beats M (next in W).
module fwd_sel_calc
  import idex_fwd_reg_b_pkg::*;
#(
  parameter int unsigned REGW = idex_fwd_reg_b_pkg::REGW
) (
  input  logic [REGW-1:0] rs_i,
  input  logic [REGW-1:0] rd_e_i,
  input  logic            regwrite_e_i,
  input  logic [REGW-1:0] rd_m_i,
  input  logic            regwrite_m_i,
  output fwd_sel_t        sel_c_o
);

  always_comb begin
    sel_c_o = FWD_RF;
    // x0 is hardwired, so it never takes a forwarded value
    if (rs_i != '0) begin
      if (regwrite_e_i && (rd_e_i == rs_i)) begin
        sel_c_o = FWD_MEM;
      end else if (regwrite_m_i && (rd_m_i == rs_i)) begin
        sel_c_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/idex_fwd_reg_b.sv
// Lane-B ID/EX register with pre-registered EX forward selects, load-use flag and bubble counter.
module idex_fwd_reg_b
  import idex_fwd_reg_b_pkg::*;
#(
  parameter int unsigned XLEN = idex_fwd_reg_b_pkg::XLEN,
  parameter int unsigned REGW = idex_fwd_reg_b_pkg::REGW,
  parameter int unsigned CNTW = idex_fwd_reg_b_pkg::CNTW
) (
  input logic           clk,
  input logic           reset,
  idex_fwd_reg_b_if.slave bus
);

  logic            valid_q,     valid_d;
  logic [XLEN-1:0] rd1_q,       rd1_d;
  logic [XLEN-1:0] rd2_q,       rd2_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [REGW-1:0] rs1_q,       rs1_d;
  logic [REGW-1:0] rs2_q,       rs2_d;
  logic [REGW-1:0] rd_q,        rd_d;
  logic            regwrite_q,  regwrite_d;
  logic            memwrite_q,  memwrite_d;
  result_src_t     res_src_q,   res_src_d;
  fwd_sel_t        fwd1_q,      fwd1_d;
  fwd_sel_t        fwd2_q,      fwd2_d;
  logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;

  fwd_sel_t fwd1_c;
  fwd_sel_t fwd2_c;

  // Compare against E (heading to M) and M (heading to W) as they stand this cycle
  fwd_sel_calc #(.REGW(REGW)) u_fwd1 (
    .rs_i         (bus.Rs1B_D),
    .rd_e_i       (rd_q),
    .regwrite_e_i (regwrite_q),
    .rd_m_i       (bus.RdB_M),
    .regwrite_m_i (bus.RegWriteB_M),
    .sel_c_o      (fwd1_c)
  );

  fwd_sel_calc #(.REGW(REGW)) u_fwd2 (
    .rs_i         (bus.Rs2B_D),
    .rd_e_i       (rd_q),
    .regwrite_e_i (regwrite_q),
    .rd_m_i       (bus.RdB_M),
    .regwrite_m_i (bus.RegWriteB_M),
    .sel_c_o      (fwd2_c)
  );

  // Next-state: stall holds, flush or invalid D inserts a bubble, otherwise load D
  always_comb begin
    valid_d      = valid_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    regwrite_d   = regwrite_q;
    memwrite_d   = memwrite_q;
    res_src_d    = res_src_q;
    fwd1_d       = fwd1_q;
    fwd2_d       = fwd2_q;
    bubble_cnt_d = bubble_cnt_q;

    if (!bus.StallB_E) begin
      if (bus.FlushB_E || !bus.ValidB_D) begin
        valid_d      = 1'b0;
        rd1_d        = '0;
        rd2_d        = '0;
        imm_d        = '0;
        pc_d         = '0;
        rs1_d        = '0;
        rs2_d        = '0;
        rd_d         = '0;
        regwrite_d   = 1'b0;
        memwrite_d   = 1'b0;
        res_src_d    = RES_ALU;
        fwd1_d       = FWD_RF;
        fwd2_d       = FWD_RF;
        bubble_cnt_d = bubble_cnt_q + CNTW'(1);
      end else begin
        valid_d      = 1'b1;
        rd1_d        = bus.RD1B_D;
        rd2_d        = bus.RD2B_D;
        imm_d        = bus.ImmExtB_D;
        pc_d         = bus.PCB_D;
        rs1_d        = bus.Rs1B_D;
        rs2_d        = bus.Rs2B_D;
        rd_d         = bus.RdB_D;
        regwrite_d   = bus.RegWriteB_D;
        memwrite_d   = bus.MemWriteB_D;
        res_src_d    = result_src_t'(bus.ResultSrcB_D);
        fwd1_d       = fwd1_c;
        fwd2_d       = fwd2_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      res_src_q    <= RES_ALU;
      fwd1_q       <= FWD_RF;
      fwd2_q       <= FWD_RF;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      regwrite_q   <= regwrite_d;
      memwrite_q   <= memwrite_d;
      res_src_q    <= res_src_d;
      fwd1_q       <= fwd1_d;
      fwd2_q       <= fwd2_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Load in E whose result a D source needs: hazard unit stalls F/D and flushes E
  assign bus.LoadUseB_D = bus.ValidB_D && (res_src_q == RES_LOAD) && regwrite_q &&
                          (rd_q != '0) &&
                          ((bus.Rs1B_D == rd_q) || (bus.Rs2B_D == rd_q));

  assign bus.ValidB_E     = valid_q;
  assign bus.RD1B_E       = rd1_q;
  assign bus.RD2B_E       = rd2_q;
  assign bus.ImmExtB_E    = imm_q;
  assign bus.PCB_E        = pc_q;
  assign bus.Rs1B_E       = rs1_q;
  assign bus.Rs2B_E       = rs2_q;
  assign bus.RdB_E        = rd_q;
  assign bus.RegWriteB_E  = regwrite_q;
  assign bus.MemWriteB_E  = memwrite_q;
  assign bus.ResultSrcB_E = res_src_q;
  assign bus.ForwardB1_E  = fwd1_q;
  assign bus.ForwardB2_E  = fwd2_q;
  assign bus.BubbleCntB   = bubble_cnt_q;

endmodule

// File: tb/tb_idex_fwd_reg_b.sv
// Bench for idex_fwd_reg_b: per-cycle model compare plus directed literal checks.
module tb_idex_fwd_reg_b;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic chk_en;

  idex_fwd_reg_b_if #(.XLEN(32), .REGW(5), .CNTW(32)) bus ();

  idex_fwd_reg_b #(.XLEN(32), .REGW(5), .CNTW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw;
    logic [1:0]  rsrc, f1, f2;
  } e_t;

  e_t          m;
  e_t          nx;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Where a source must be read from next cycle, given who writes what now
  function automatic logic [1:0] fwd_exp(input logic [4:0] s);
    if (s == 5'd0) return 2'b00;
    if (m.rw && m.rd == s) return 2'b10;
    if (bus.RegWriteB_M && bus.RdB_M == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic loaduse_exp();
    return bus.ValidB_D && m.rsrc == 2'b01 && m.rw && m.rd != 5'd0 &&
           (bus.Rs1B_D == m.rd || bus.Rs2B_D == m.rd);
  endfunction

  // Model of E-stage contents
  always @(posedge clk) begin
    nx = m;
    if (reset) begin
      nx = '{default: '0};
      m_cnt <= 32'd0;
    end else if (!bus.StallB_E) begin
      if (bus.FlushB_E || !bus.ValidB_D) begin
        nx = '{default: '0};
        m_cnt <= m_cnt + 32'd1;
      end else begin
        nx.valid = 1'b1;
        nx.rd1 = bus.RD1B_D;  nx.rd2 = bus.RD2B_D;
        nx.imm = bus.ImmExtB_D; nx.pc = bus.PCB_D;
        nx.rs1 = bus.Rs1B_D;  nx.rs2 = bus.Rs2B_D; nx.rd = bus.RdB_D;
        nx.rw = bus.RegWriteB_D; nx.mw = bus.MemWriteB_D;
        nx.rsrc = bus.ResultSrcB_D;
        nx.f1 = fwd_exp(bus.Rs1B_D);
        nx.f2 = fwd_exp(bus.Rs2B_D);
      end
    end
    m <= nx;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ValidB_E",     64'(bus.ValidB_E),     64'(m.valid));
      chk("RD1B_E",       64'(bus.RD1B_E),       64'(m.rd1));
      chk("RD2B_E",       64'(bus.RD2B_E),       64'(m.rd2));
      chk("ImmExtB_E",    64'(bus.ImmExtB_E),    64'(m.imm));
      chk("PCB_E",        64'(bus.PCB_E),        64'(m.pc));
      chk("Rs1B_E",       64'(bus.Rs1B_E),       64'(m.rs1));
      chk("Rs2B_E",       64'(bus.Rs2B_E),       64'(m.rs2));
      chk("RdB_E",        64'(bus.RdB_E),        64'(m.rd));
      chk("RegWriteB_E",  64'(bus.RegWriteB_E),  64'(m.rw));
      chk("MemWriteB_E",  64'(bus.MemWriteB_E),  64'(m.mw));
      chk("ResultSrcB_E", 64'(bus.ResultSrcB_E), 64'(m.rsrc));
      chk("ForwardB1_E",  64'(bus.ForwardB1_E),  64'(m.f1));
      chk("ForwardB2_E",  64'(bus.ForwardB2_E),  64'(m.f2));
      chk("BubbleCntB",   64'(bus.BubbleCntB),   64'(m_cnt));
      chk("LoadUseB_D",   64'(bus.LoadUseB_D),   64'(loaduse_exp()));
    end
  end

  task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mw,
                       input logic [1:0] rsrc, input logic [31:0] pc);
    bus.ValidB_D     = v;
    bus.Rs1B_D       = rs1;
    bus.Rs2B_D       = rs2;
    bus.RdB_D        = rd;
    bus.RegWriteB_D  = rw;
    bus.MemWriteB_D  = mw;
    bus.ResultSrcB_D = rsrc;
    bus.PCB_D        = pc;
    bus.RD1B_D       = pc + 32'h1000;
    bus.RD2B_D       = pc ^ 32'hFFFF0000;
    bus.ImmExtB_D    = pc + 32'd4;
  endtask

  task automatic set_m(input logic [4:0] rd, input logic rw);
    bus.RdB_M       = rd;
    bus.RegWriteB_M = rw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; chk_en = 1'b0; n_tests = 0; n_fail = 0;
    m = '{default: '0}; m_cnt = 32'd0;
    bus.StallB_E = 1'b0; bus.FlushB_E = 1'b0;
    set_d(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0);
    set_m(5'd0, 1'b0);
    tick();

    // Reset dominates stall and flush with valid D data
    bus.StallB_E = 1'b1; bus.FlushB_E = 1'b1;
    set_d(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 2'b10, 32'h40);
    tick();
    chk("rst_valid", 64'(bus.ValidB_E), 64'd0);
    chk("rst_pc",    64'(bus.PCB_E),    64'd0);
    chk("rst_cnt",   64'(bus.BubbleCntB), 64'd0);
    chk("rst_rw",    64'(bus.RegWriteB_E), 64'd0);
    chk("rst_fwd1",  64'(bus.ForwardB1_E), 64'd0);
    chk_en = 1'b1;
    reset = 1'b0; bus.StallB_E = 1'b0; bus.FlushB_E = 1'b0;

    // Back-to-back dependency on x5
    set_d(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 2'b00, 32'h200);
    tick();
    set_d(1'b1, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0, 2'b00, 32'h204);
    tick();
    chk("b2b_fwd2",  64'(bus.ForwardB2_E), 64'h2);
    chk("b2b_fwd1",  64'(bus.ForwardB1_E), 64'h0);
    chk("b2b_valid", 64'(bus.ValidB_E),    64'h1);

    // Double match on x7: E wins; then E not writing so M wins
    set_d(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 2'b00, 32'h208);
    tick();
    set_m(5'd7, 1'b1);
    set_d(1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 2'b00, 32'h20C);
    tick();
    chk("dbl_e_wins", 64'(bus.ForwardB1_E), 64'h2);
    set_d(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 2'b00, 32'h210);
    tick();
    chk("dbl_m_only", 64'(bus.ForwardB1_E), 64'h1);

    // x0 guard
    set_m(5'd0, 1'b1);
    set_d(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 2'b00, 32'h214);
    tick();
    set_d(1'b1, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 2'b01, 32'h218);
    tick();
    chk("x0_fwd1", 64'(bus.ForwardB1_E), 64'h0);
    set_d(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 2'b00, 32'h21C);
    #1;
    chk("x0_loaduse", 64'(bus.LoadUseB_D), 64'h0);

    // Load-use on x9, answered with a flush
    set_m(5'd0, 1'b0);
    set_d(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 2'b01, 32'h220);
    tick();
    set_d(1'b1, 5'd9, 5'd2, 5'd10, 1'b1, 1'b0, 2'b00, 32'h224);
    #1;
    chk("lu_detect", 64'(bus.LoadUseB_D), 64'h1);
    bus.FlushB_E = 1'b1;
    tick();
    bus.FlushB_E = 1'b0;
    chk("lu_valid", 64'(bus.ValidB_E),    64'h0);
    chk("lu_rw",    64'(bus.RegWriteB_E), 64'h0);
    chk("lu_cnt",   64'(bus.BubbleCntB),  64'd1);

    // Stall hold with changing D inputs
    set_m(5'd12, 1'b1);
    set_d(1'b1, 5'd1, 5'd12, 5'd13, 1'b1, 1'b0, 2'b00, 32'h100);
    tick();
    chk("st_pc0",   64'(bus.PCB_E),       64'h100);
    chk("st_fwd20", 64'(bus.ForwardB2_E), 64'h1);
    bus.StallB_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_d(1'(i % 2), 5'(i + 1), 5'(i + 2), 5'(i + 3), 1'b1, 1'b1, 2'b10, 32'h300 + 32'(i));
      if (i == 2) bus.FlushB_E = 1'b1;
      tick();
      chk("st_pc",   64'(bus.PCB_E),       64'h100);
      chk("st_fwd2", 64'(bus.ForwardB2_E), 64'h1);
      chk("st_cnt",  64'(bus.BubbleCntB),  64'd1);
    end
    bus.StallB_E = 1'b0; bus.FlushB_E = 1'b0;

    // Invalid D without stall is a bubble
    set_d(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 2'b01, 32'h400);
    tick();
    chk("inv_cnt",   64'(bus.BubbleCntB), 64'd2);
    chk("inv_valid", 64'(bus.ValidB_E),   64'd0);

    // Mixed traffic over a small register range
    for (int i = 0; i < 60; i++) begin
      set_d(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 2)), 32'h1000 + 32'(i * 4));
      set_m(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      bus.StallB_E = 1'($urandom_range(0, 7) == 0);
      bus.FlushB_E = 1'($urandom_range(0, 7) == 0);
      tick();
    end
    bus.StallB_E = 1'b0; bus.FlushB_E = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
